// File: rtl/bin_to_bcd_serial_if.sv
// bin_to_bcd_serial_if: start/done handshake and result bus of the serial binary-to-BCD converter
interface bin_to_bcd_serial_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;
   modport master (output start, bin, input busy, done, bcd, overflow);
   modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: double-dabble binary-to-BCD converter, one input bit per clock
module bin_to_bcd_serial #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   bin_to_bcd_serial_if.slave   bus
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam int DW = 4 * DIGITS;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state;
   logic [BIN_W-1:0]  sh;
   logic [DW-1:0]     scr;
   logic              ovf_s;
   logic [CW-1:0]     cnt;
   logic [DW-1:0]     adj;
   logic [DW-1:0]     nscr;
   logic [BIN_W-1:0]  nsh;
   logic              nov;
   // one double-dabble iteration: add 3 to digits >= 5, shift left, catch the bit leaving the top digit
   always_comb begin
      adj = '0;
      for (int k = 0; k < DIGITS; k++)
         adj[4*k+:4] = scr[4*k+:4] >= 4'd5 ? scr[4*k+:4] + 4'd3 : scr[4*k+:4];
      {nscr, nsh} = {adj[DW-2:0], sh, 1'b0};
      nov = ovf_s | adj[DW-1];
   end
   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sh           <= '0;
         scr          <= '0;
         ovf_s        <= 1'b0;
         cnt          <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd      <= '0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               sh       <= bus.bin;
               scr      <= '0;
               ovf_s    <= 1'b0;
               cnt      <= CW'(BIN_W);
               bus.busy <= 1'b1;
               state    <= SHIFT;
            end
            SHIFT: begin
               sh    <= nsh;
               scr   <= nscr;
               ovf_s <= nov;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.bcd      <= nscr;
                  bus.overflow <= nov;
                  bus.done     <= 1'b1;
                  bus.busy     <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb_bin_to_bcd_serial: directed checks of the serial BCD converter at 3 and 2 digits
module tb_bin_to_bcd_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [11:0] r_bcd;
   logic        r_ovf;
   bin_to_bcd_serial_if #(.BIN_W(8), .DIGITS(3)) ia ();
   bin_to_bcd_serial_if #(.BIN_W(8), .DIGITS(2)) ib ();
   bin_to_bcd_serial #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   bin_to_bcd_serial #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // start a conversion on DUT a (sel=0) or b (sel=1), follow it to done, capture the result
   task automatic run(input bit sel, input logic [7:0] v, input bit poke);
      int lat;
      lat = 0;
      if (sel) begin ib.start = 1'b1; ib.bin = v; end
      else begin ia.start = 1'b1; ia.bin = v; end
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      ib.start = 1'b0;
      chk("busy_after_accept", sel ? ib.busy : ia.busy, 1);
      chk("done_low_after_accept", sel ? ib.done : ia.done, 0);
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         if (poke && i == 3) begin ia.start = 1'b1; ia.bin = 8'd200; end
         if (poke && i == 4) begin ia.start = 1'b0; ia.bin = 8'd99; end
         @(negedge clk);
         if (sel ? ib.done : ia.done) lat = i;
         else chk("busy_mid", sel ? ib.busy : ia.busy, 1);
      end
      chk("latency", lat, 8);
      chk("busy_at_done", sel ? ib.busy : ia.busy, 0);
      r_bcd = sel ? {4'h0, ib.bcd} : ia.bcd;
      r_ovf = sel ? ib.overflow : ia.overflow;
   endtask

   initial begin
      int dones;
      logic [11:0] exp_bcd;
      ia.start = 1'b0; ia.bin = '0;
      ib.start = 1'b0; ib.bin = '0;
      #1;
      chk("reset_busy", ia.busy, 0);
      chk("reset_done", ia.done, 0);
      chk("reset_bcd", ia.bcd, 0);
      chk("reset_ovf", ia.overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(0, 8'd255, 0);
      chk("bcd_255", r_bcd, 12'h255);
      chk("ovf_255", r_ovf, 0);
      @(negedge clk);
      run(0, 8'd0, 0);
      chk("bcd_0", r_bcd, 12'h000);
      chk("ovf_0", r_ovf, 0);
      @(negedge clk);
      run(0, 8'd99, 0);
      chk("bcd_99", r_bcd, 12'h099);
      @(negedge clk);
      run(0, 8'd37, 1);
      chk("bcd_37_ignore_busy_start", r_bcd, 12'h037);
      run(0, 8'd200, 0);
      chk("bcd_200_back_to_back", r_bcd, 12'h200);
      repeat (4) @(negedge clk);
      chk("bcd_hold", ia.bcd, 12'h200);
      chk("done_single_pulse", ia.done, 0);
      run(1, 8'd150, 0);
      chk("d2_bcd_150", r_bcd, 12'h050);
      chk("d2_ovf_150", r_ovf, 1);
      @(negedge clk);
      run(1, 8'd100, 0);
      chk("d2_bcd_100", r_bcd, 12'h000);
      chk("d2_ovf_100", r_ovf, 1);
      @(negedge clk);
      run(1, 8'd99, 0);
      chk("d2_bcd_99", r_bcd, 12'h099);
      chk("d2_ovf_99", r_ovf, 0);
      @(negedge clk);
      ia.start = 1'b1;
      ia.bin = 8'd128;
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", ia.busy, 0);
      chk("async_rst_done", ia.done, 0);
      chk("async_rst_bcd", ia.bcd, 0);
      chk("async_rst_ovf", ia.overflow, 0);
      chk("async_rst_bcd_b", ib.bcd, 0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (ia.done) dones++;
      end
      chk("no_done_after_abort", dones, 0);
      run(0, 8'd128, 0);
      chk("bcd_128_after_reset", r_bcd, 12'h128);
      for (int v = 0; v < 256; v++) begin
         run(0, 8'(v), 0);
         exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         chk($sformatf("sweep_bcd_%0d", v), r_bcd, exp_bcd);
         chk($sformatf("sweep_nibbles_%0d", v),
             (r_bcd[3:0] <= 9 && r_bcd[7:4] <= 9 && r_bcd[11:8] <= 9), 1);
         @(negedge clk);
         chk($sformatf("sweep_done_width_%0d", v), ia.done, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
